// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: RV32I load/store front-end for a single-port word RAM with
// asynchronous read and synchronous write. Sub-word stores are done as a
// read-merge-write sequence through a merge register.
// Optional macro LSU_MISALIGN_TRAP_EN: a misaligned access skips the RAM and
// completes at once with MISALIGNED = 1. Without it MISALIGNED is tied low and
// the low address bits are forced to natural alignment.
module lsu_dmem_ctrl #(
    parameter int ADDRESS_SIZE = 1024
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            REQ_VALID,
    input  logic                            REQ_WRITE,
    input  logic [2:0]                      REQ_FUNCT3,
    input  logic [31:0]                     REQ_ADDR,
    input  logic [31:0]                     REQ_WDATA,
    output logic                            REQ_READY,
    output logic                            RESP_VALID,
    output logic [31:0]                     RESP_RDATA,
    output logic                            MISALIGNED,
    output logic                            STALL,
    output logic [$clog2(ADDRESS_SIZE)-1:0] MEM_ADDRESS,
    output logic                            MEM_WRITE,
    output logic [31:0]                     MEM_WRITE_DATA,
    input  logic [31:0]                     MEM_READ_DATA
);

    localparam int AW = $clog2(ADDRESS_SIZE);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, DONE} state_t;

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   merge_q, merge_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mis_q, mis_d;

    // Address bits above the RAM depth are ignored, so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^REQ_ADDR[31:AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
    // size: 00 byte, 01 halfword, 1x word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction
`else
    // Clear the low address bits that natural alignment forbids for this size.
    function automatic logic [1:0] align_low(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return a;
            2'b01:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction
`endif

    // Pick the addressed byte/halfword out of the RAM word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    // Replace the addressed byte (is_half = 0) or halfword lane of the RAM word.
    function automatic logic [31:0] store_merge(input logic is_half, input logic [1:0] a,
                                                input logic [31:0] word, input logic [15:0] wd);
        logic [31:0] mask;
        logic [31:0] lane;
        if (is_half) begin
            mask = 32'h0000_FFFF << {a[1], 4'b0000};
            lane = {16'h0, wd} << {a[1], 4'b0000};
        end else begin
            mask = 32'h0000_00FF << {a, 3'b000};
            lane = {24'h0, wd[7:0]} << {a, 3'b000};
        end
        return (word & ~mask) | lane;
    endfunction

    // Next-state and register-update logic of the access sequencer.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    write_d  = REQ_WRITE;
                    funct3_d = REQ_FUNCT3;
                    wdata_d  = REQ_WDATA;
`ifdef LSU_MISALIGN_TRAP_EN
                    addr_d  = REQ_ADDR[AW+1:0];
                    mis_d   = is_misaligned(REQ_FUNCT3[1:0], REQ_ADDR[1:0]);
                    state_d = mis_d ? DONE : ACCESS;
`else
                    addr_d  = {REQ_ADDR[AW+1:2], align_low(REQ_FUNCT3[1:0], REQ_ADDR[1:0])};
                    mis_d   = 1'b0;
                    state_d = ACCESS;
`endif
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    rdata_d = load_extract(funct3_q, addr_q[1:0], MEM_READ_DATA);
                    state_d = DONE;
                end else if (funct3_q[1]) begin
                    // full-word store is written during this cycle
                    state_d = DONE;
                end else begin
                    merge_d = store_merge(funct3_q[0], addr_q[1:0], MEM_READ_DATA,
                                          wdata_q[15:0]);
                    state_d = MERGE_WR;
                end
            end
            MERGE_WR: state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode; RAM writes are suppressed whenever RESET is high.
    always_comb begin
        REQ_READY      = state_q == IDLE;
        STALL          = state_q != IDLE;
        RESP_VALID     = (state_q == DONE) && !RESET;
        MEM_ADDRESS    = addr_q[AW+1:2];
        MEM_WRITE      = 1'b0;
        MEM_WRITE_DATA = 32'h0;
        if (!RESET) begin
            if (state_q == ACCESS && write_q && funct3_q[1]) begin
                MEM_WRITE      = 1'b1;
                MEM_WRITE_DATA = wdata_q;
            end else if (state_q == MERGE_WR) begin
                MEM_WRITE      = 1'b1;
                MEM_WRITE_DATA = merge_q;
            end
        end
        RESP_RDATA = (state_q == DONE && (write_q || mis_q)) ? 32'h0 : rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        MISALIGNED = (state_q == DONE) && mis_q && !RESET;
`else
        MISALIGNED = 1'b0;
`endif
    end

    // State and request registers with synchronous clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
        end
    end

endmodule
